id_ex_reg: RTL and testbench

Pipeline register between the decode stage and the execute stage of the five-stage ARM core. It captures the decode stage's control word, the two operand values read from the register file (`reg1`/`reg2`), the immediate/shift fields, the destination and source register numbers, the PC and the status-register flags. It presents them to execute one cycle later. It supports freeze (stall hold), flush (branch bubble) and a valid bit that later stages and the forwarding unit qualify on.

---
 rtl/id_ex_reg.sv | 119 +++++++++++
 tb/tb_id_ex_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register.
// Holds on freeze, bubbles on flush, and tags each entry with a valid bit.
module id_ex_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] val_rn_in,
  input  logic [WIDTH-1:0] val_rm_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       sr_in,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic [3:0]       exe_cmd_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] val_rn_out,
  output logic [WIDTH-1:0] val_rm_out,
  output logic             imm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       sr_out,
  output logic             valid_out
);

  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic [3:0]       exe_cmd;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic             imm;
    logic [11:0]      shift_operand;
    logic [23:0]      signed_imm24;
    logic [3:0]       dest;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic [3:0]       sr;
  } id_ex_t;

  id_ex_t nxt;
  id_ex_t q;
  logic   valid_q;

  // Build the load word; a non-instruction must not carry side effects.
  always_comb begin
    nxt               = '0;
    nxt.wb_en         = wb_en_in & id_valid;
    nxt.mem_r_en      = mem_r_en_in & id_valid;
    nxt.mem_w_en      = mem_w_en_in & id_valid;
    nxt.b             = b_in & id_valid;
    nxt.s             = s_in & id_valid;
    nxt.exe_cmd       = exe_cmd_in;
    nxt.pc            = pc_in;
    nxt.val_rn        = val_rn_in;
    nxt.val_rm        = val_rm_in;
    nxt.imm           = imm_in;
    nxt.shift_operand = shift_operand_in;
    nxt.signed_imm24  = signed_imm24_in;
    nxt.dest          = dest_in;
    nxt.src1          = src1_in;
    nxt.src2          = src2_in;
    nxt.sr            = sr_in;
  end

  // Reset and flush both clear everything; freeze holds; otherwise load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q       <= '0;
      valid_q <= 1'b0;
    end else if (!freeze) begin
      q       <= nxt;
      valid_q <= id_valid;
    end
  end

  assign wb_en_out         = q.wb_en;
  assign mem_r_en_out      = q.mem_r_en;
  assign mem_w_en_out      = q.mem_w_en;
  assign b_out             = q.b;
  assign s_out             = q.s;
  assign exe_cmd_out       = q.exe_cmd;
  assign pc_out            = q.pc;
  assign val_rn_out        = q.val_rn;
  assign val_rm_out        = q.val_rm;
  assign imm_out           = q.imm;
  assign shift_operand_out = q.shift_operand;
  assign signed_imm24_out  = q.signed_imm24;
  assign dest_out          = q.dest;
  assign src1_out          = q.src1;
  assign src2_out          = q.src2;
  assign sr_out            = q.sr;
  assign valid_out         = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed plus random checks of id_ex_reg
// against a queue-based scoreboard.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic [3:0]  cmd;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  sr;
  } word_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  freeze = 1'b0;
  logic  flush = 1'b0;
  word_t din = '0;
  word_t obs;
  word_t mdl = '0;
  word_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  logic        wb_o, mr_o, mw_o, b_o, s_o;
  logic        imm_o, val_o;
  logic [3:0]  cmd_o, dest_o, src1_o, src2_o, sr_o;
  logic [31:0] pc_o, rn_o, rm_o;
  logic [11:0] sh_o;
  logic [23:0] si_o;

  always #5 clk = ~clk;

  id_ex_reg #(.WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .flush            (flush),
    .id_valid         (din.valid),
    .wb_en_in         (din.wb),
    .mem_r_en_in      (din.mr),
    .mem_w_en_in      (din.mw),
    .b_in             (din.b),
    .s_in             (din.s),
    .exe_cmd_in       (din.cmd),
    .pc_in            (din.pc),
    .val_rn_in        (din.rn),
    .val_rm_in        (din.rm),
    .imm_in           (din.imm),
    .shift_operand_in (din.sh),
    .signed_imm24_in  (din.si),
    .dest_in          (din.dest),
    .src1_in          (din.src1),
    .src2_in          (din.src2),
    .sr_in            (din.sr),
    .wb_en_out        (wb_o),
    .mem_r_en_out     (mr_o),
    .mem_w_en_out     (mw_o),
    .b_out            (b_o),
    .s_out            (s_o),
    .exe_cmd_out      (cmd_o),
    .pc_out           (pc_o),
    .val_rn_out       (rn_o),
    .val_rm_out       (rm_o),
    .imm_out          (imm_o),
    .shift_operand_out(sh_o),
    .signed_imm24_out (si_o),
    .dest_out         (dest_o),
    .src1_out         (src1_o),
    .src2_out         (src2_o),
    .sr_out           (sr_o),
    .valid_out        (val_o)
  );

  assign obs = {val_o, wb_o, mr_o, mw_o, b_o, s_o, cmd_o,
                pc_o, rn_o, rm_o, imm_o, sh_o, si_o,
                dest_o, src1_o, src2_o, sr_o};

  function automatic word_t rand_word();
    word_t w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w;
  endfunction

  // Drive one cycle of stimulus, predict, then check after the edge.
  task automatic step(input string tag, input logic r,
                      input logic f, input logic fz,
                      input word_t in);
    word_t e;
    @(negedge clk);
    rst    = r;
    freeze = fz;
    flush  = f;
    din    = in;
    if (r || f) begin
      mdl = '0;
    end else if (!fz) begin
      mdl = in;
      if (!in.valid) begin
        mdl.wb = 1'b0;
        mdl.mr = 1'b0;
        mdl.mw = 1'b0;
        mdl.b  = 1'b0;
        mdl.s  = 1'b0;
      end
    end
    exp_q.push_back(mdl);
    @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, got %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  initial begin
    word_t w;
    w = '1;
    step("rst0", 1'b1, 1'b0, 1'b0, w);
    step("rst1", 1'b1, 1'b0, 1'b0, w);
    w = '0;
    w.valid = 1'b1;
    w.pc = 32'h4;
    step("first_load", 1'b0, 1'b0, 1'b0, w);
    n_chk++;
    assert (pc_o === 32'h4 && val_o === 1'b1) else begin
      n_fail++;
      $error("FAIL first_pc: got %h/%b expected 4/1", pc_o, val_o);
    end
    w = '0;
    w.valid = 1'b1;
    w.cmd = 4'b0010;
    w.rn = 32'h12;
    w.rm = 32'h34;
    w.dest = 4'd2;
    w.wb = 1'b1;
    step("load", 1'b0, 1'b0, 1'b0, w);
    w = '0;
    w.valid = 1'b1;
    w.pc = 32'h8;
    w.wb = 1'b1;
    step("load_pc8", 1'b0, 1'b0, 1'b0, w);
    w.pc = 32'hC;
    w.dest = 4'd7;
    for (int i = 0; i < 3; i++)
      step("freeze", 1'b0, 1'b0, 1'b1, w);
    n_chk++;
    assert (pc_o === 32'h8) else begin
      n_fail++;
      $error("FAIL freeze_pc: got %h expected 8", pc_o);
    end
    step("unfreeze", 1'b0, 1'b0, 1'b0, w);
    w = '0;
    w.valid = 1'b1;
    w.wb = 1'b1;
    w.dest = 4'd5;
    step("load_d5", 1'b0, 1'b0, 1'b0, w);
    step("flush_frz", 1'b0, 1'b1, 1'b1, w);
    w = rand_word();
    w.valid = 1'b0;
    w.mw = 1'b1;
    w.b = 1'b1;
    step("invalid", 1'b0, 1'b0, 1'b0, w);
    w = rand_word();
    w.valid = 1'b1;
    w.pc = 32'h10;
    step("load_pc10", 1'b0, 1'b0, 1'b0, w);
    w = rand_word();
    step("rst_frz", 1'b1, 1'b0, 1'b1, w);
    w = rand_word();
    w.valid = 1'b1;
    step("post_rst", 1'b0, 1'b0, 1'b0, w);
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'b0, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), rand_word());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
